// File: rtl/hazard_unit_if.sv
// hazard_unit_if: decode/execute hazard inputs and upstream pipeline controls
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_q2_rs1;
    logic [4:0]       i_q2_rs2;
    logic             i_q2_uses_rs1;
    logic             i_q2_uses_rs2;
    logic [4:0]       i_q3_rd;
    logic             i_q3_mem_read;
    logic             i_q3_redirect;
    logic             i_q3_mc_start;
    logic             i_mc_done;
    logic             o_stall_q1;
    logic             o_bubble_q2q3;
    logic             o_flush_q1q2;
    logic             o_hold_q3;
    logic [CNT_W-1:0] o_stall_cycles;
    logic [CNT_W-1:0] o_flush_count;

    modport master (
        output i_q2_rs1, i_q2_rs2, i_q2_uses_rs1, i_q2_uses_rs2, i_q3_rd,
               i_q3_mem_read, i_q3_redirect, i_q3_mc_start, i_mc_done,
        input  o_stall_q1, o_bubble_q2q3, o_flush_q1q2, o_hold_q3,
               o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_q2_rs1, i_q2_rs2, i_q2_uses_rs1, i_q2_uses_rs2, i_q3_rd,
               i_q3_mem_read, i_q3_redirect, i_q3_mc_start, i_mc_done,
        output o_stall_q1, o_bubble_q2q3, o_flush_q1q2, o_hold_q3,
               o_stall_cycles, o_flush_count
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, redirect flush and multi-cycle hold control with perf counters
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hazard_unit_if.slave  bus
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] MCWAIT = 2'd2;
    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, in_run, in_flush, in_mcwait;
    logic             redir_acc, mc_stall, lu_stall, stall, bubble, flush, hold;

    // decode hazards and the raw (pre-reset-gating) control decisions
    always_comb begin
        lu        = bus.i_q3_mem_read && bus.i_q3_rd != 5'd0 &&
                    ((bus.i_q2_uses_rs1 && bus.i_q2_rs1 == bus.i_q3_rd) ||
                     (bus.i_q2_uses_rs2 && bus.i_q2_rs2 == bus.i_q3_rd));
        in_run    = state_q == RUN;
        in_flush  = state_q == FLUSH;
        in_mcwait = state_q == MCWAIT;
        redir_acc = (in_run || in_flush) && bus.i_q3_redirect;
        mc_stall  = (in_run && !bus.i_q3_redirect && bus.i_q3_mc_start && !bus.i_mc_done) ||
                    (in_mcwait && !bus.i_mc_done);
        lu_stall  = in_run && !bus.i_q3_redirect && !bus.i_q3_mc_start && lu;
        stall     = mc_stall || lu_stall;
        hold      = mc_stall;
        bubble    = redir_acc || lu_stall;
        flush     = (in_run && bus.i_q3_redirect) || in_flush;
    end

    // outputs are forced low for as long as reset is held
    always_comb begin
        bus.o_stall_q1     = !i_rst && stall;
        bus.o_bubble_q2q3  = !i_rst && bubble;
        bus.o_flush_q1q2   = !i_rst && flush;
        bus.o_hold_q3      = !i_rst && hold;
        bus.o_stall_cycles = stall_cnt_q;
        bus.o_flush_count  = flush_cnt_q;
    end

    // next state, flush countdown and saturating counter updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (redir_acc && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        if (in_run) begin
            if (bus.i_q3_redirect) begin
                state_d = (RELOAD != 4'd0) ? FLUSH : RUN;
                cnt_d   = RELOAD;
            end else if (bus.i_q3_mc_start && !bus.i_mc_done) begin
                state_d = MCWAIT;
            end
        end else if (in_flush) begin
            if (bus.i_q3_redirect) begin
                cnt_d = RELOAD;
            end else begin
                state_d = (cnt_q <= 4'd1) ? RUN : FLUSH;
                cnt_d   = (cnt_q <= 4'd1) ? 4'd0 : cnt_q - 4'd1;
            end
        end else if (in_mcwait) begin
            state_d = bus.i_mc_done ? RUN : MCWAIT;
        end else begin
            state_d = RUN;
        end
    end

    // state and counter registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors for hazard_unit with FLUSH_CYCLES=2, CNT_W=4
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_if #(.CNT_W(4)) hif ();

    hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic b, input logic f, input logic h);
        check({tag, ".stall"},  32'(hif.o_stall_q1),    32'(s));
        check({tag, ".bubble"}, 32'(hif.o_bubble_q2q3), 32'(b));
        check({tag, ".flush"},  32'(hif.o_flush_q1q2),  32'(f));
        check({tag, ".hold"},   32'(hif.o_hold_q3),     32'(h));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        hif.i_q2_rs1 = 5'd0; hif.i_q2_rs2 = 5'd0;
        hif.i_q2_uses_rs1 = 1'b0; hif.i_q2_uses_rs2 = 1'b0;
        hif.i_q3_rd = 5'd0; hif.i_q3_mem_read = 1'b0;
        hif.i_q3_redirect = 1'b0; hif.i_q3_mc_start = 1'b0; hif.i_mc_done = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        hif.i_q3_mem_read = 1'b1; hif.i_q3_rd = rd;
        hif.i_q2_rs1 = rs1; hif.i_q2_uses_rs1 = u1;
        hif.i_q2_rs2 = rs2; hif.i_q2_uses_rs2 = u2;
    endtask

    initial begin
        idle();
        tick(); tick();
        chk_out("rst", 0, 0, 0, 0);
        check("rst.stall_cycles", 32'(hif.o_stall_cycles), 0);
        check("rst.flush_count", 32'(hif.o_flush_count), 0);
        rst = 1'b0;
        tick();
        #1 chk_out("idle", 0, 0, 0, 0);
        tick();

        // load-use through rs2
        set_lu(5'd5, 5'd0, 0, 5'd5, 1); #1;
        chk_out("lu_rs2", 1, 1, 0, 0);
        tick(); idle(); #1;
        check("lu.stall_cycles", 32'(hif.o_stall_cycles), 1);
        chk_out("lu.after", 0, 0, 0, 0);
        set_lu(5'd0, 5'd0, 0, 5'd0, 1); #1;
        chk_out("lu_rd0", 0, 0, 0, 0);
        set_lu(5'd5, 5'd0, 0, 5'd5, 0); #1;
        chk_out("lu_nouse", 0, 0, 0, 0);
        set_lu(5'd7, 5'd7, 1, 5'd3, 1); #1;
        chk_out("lu_rs1", 1, 1, 0, 0);
        tick(); idle(); #1;
        check("lu2.stall_cycles", 32'(hif.o_stall_cycles), 2);

        // redirect, LU during flush ignored
        hif.i_q3_redirect = 1'b1; #1;
        chk_out("redir.n", 0, 1, 1, 0);
        tick(); idle(); set_lu(5'd5, 5'd0, 0, 5'd5, 1); #1;
        chk_out("redir.n1_lu", 0, 0, 1, 0);
        tick(); idle(); #1;
        chk_out("redir.n2", 0, 0, 1, 0);
        tick(); #1;
        chk_out("redir.n3", 0, 0, 0, 0);
        check("redir.flush_count", 32'(hif.o_flush_count), 1);
        check("redir.stall_cycles", 32'(hif.o_stall_cycles), 2);

        // redirect with mc_start: flush only, no MCWAIT
        hif.i_q3_redirect = 1'b1; hif.i_q3_mc_start = 1'b1; #1;
        chk_out("redmc.n", 0, 1, 1, 0);
        tick(); idle(); #1;
        chk_out("redmc.n1", 0, 0, 1, 0);
        tick(); #1;
        chk_out("redmc.n2", 0, 0, 1, 0);
        tick(); #1;
        chk_out("redmc.n3", 0, 0, 0, 0);
        check("redmc.flush_count", 32'(hif.o_flush_count), 2);

        // redirect inside FLUSH reloads the window
        hif.i_q3_redirect = 1'b1; #1;
        tick(); #1;
        chk_out("rerd.n1", 0, 1, 1, 0);
        tick(); idle(); #1;
        chk_out("rerd.n2", 0, 0, 1, 0);
        tick(); #1;
        chk_out("rerd.n3", 0, 0, 1, 0);
        tick(); #1;
        chk_out("rerd.n4", 0, 0, 0, 0);
        check("rerd.flush_count", 32'(hif.o_flush_count), 4);

        // multi-cycle start then done four cycles later; redirect ignored in MCWAIT
        hif.i_q3_mc_start = 1'b1; #1;
        chk_out("mc.n", 1, 0, 0, 1);
        for (int i = 1; i < 5; i++) begin
            tick(); idle();
            if (i == 2) hif.i_q3_redirect = 1'b1;
            #1 chk_out($sformatf("mc.n%0d", i), 1, 0, 0, 1);
        end
        tick(); idle(); hif.i_mc_done = 1'b1; #1;
        chk_out("mc.done", 0, 0, 0, 0);
        tick(); idle(); #1;
        chk_out("mc.after", 0, 0, 0, 0);
        check("mc.stall_cycles", 32'(hif.o_stall_cycles), 7);
        check("mc.flush_count", 32'(hif.o_flush_count), 4);

        // start and done together: no stall
        hif.i_q3_mc_start = 1'b1; hif.i_mc_done = 1'b1; #1;
        chk_out("mcsame", 0, 0, 0, 0);
        tick(); idle(); #1;
        chk_out("mcsame.after", 0, 0, 0, 0);
        check("mcsame.stall_cycles", 32'(hif.o_stall_cycles), 7);

        // async reset mid-MCWAIT
        hif.i_q3_mc_start = 1'b1;
        tick(); idle(); #1;
        chk_out("rstmc.wait", 1, 0, 0, 1);
        rst = 1'b1; #1;
        chk_out("rstmc.during", 0, 0, 0, 0);
        check("rstmc.stall_cycles", 32'(hif.o_stall_cycles), 0);
        check("rstmc.flush_count", 32'(hif.o_flush_count), 0);
        tick(); rst = 1'b0;
        tick(); #1;
        chk_out("rstmc.run", 0, 0, 0, 0);
        set_lu(5'd9, 5'd9, 1, 5'd0, 0); #1;
        chk_out("rstmc.lu", 1, 1, 0, 0);
        tick(); #1;
        check("rstmc.lu_cycles", 32'(hif.o_stall_cycles), 1);

        // saturation: 20 more stall cycles
        for (int i = 0; i < 20; i++) tick();
        #1 chk_out("sat.lu", 1, 1, 0, 0);
        check("sat.stall_cycles", 32'(hif.o_stall_cycles), 15);
        idle(); tick(); #1;
        check("sat.hold_15", 32'(hif.o_stall_cycles), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. It watches the instruction in decode (q2) and the instruction in execute (q3) and drives hold, bubble and flush controls back upstream into the fetch/PC logic, the q1q2 register and the q2q3 register. It covers three cases: load-use stalls, taken-branch/jump redirects and multi-cycle execute ops. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
Parameters:
- FLUSH_CYCLES, 1: extra cycles after a redirect during which q1q2 stays flushed (covers fetch latency); legal range 0–15.
- CNT_W, 32: width of the performance counters.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high. Clears all state; all outputs are forced to 0 while asserted.
- i_q2_rs1  in  5  rs1 index of the decode-stage instruction.
- i_q2_rs2  in  5  rs2 index of the decode-stage instruction.
- i_q2_uses_rs1  in  1  decode-stage instruction reads rs1.
- i_q2_uses_rs2  in  1  decode-stage instruction reads rs2.
- i_q3_rd  in  5  destination register of the execute-stage instruction.
- i_q3_mem_read  in  1  execute-stage instruction is a load.
- i_q3_redirect  in  1  execute resolved a taken branch/jump this cycle.
- i_q3_mc_start  in  1  execute began a multi-cycle op this cycle (single-cycle pulse).
- i_mc_done  in  1  multi-cycle unit result is valid this cycle.
- o_stall_q1  out  1  hold PC and q1q2 (no update).
- o_bubble_q2q3  out  1  load NOP (32'h00000013, ctrl 0) into q2q3 instead of the decode output.
- o_flush_q1q2  out  1  load NOP into q1q2 instead of the fetched instruction.
- o_hold_q3  out  1  hold q2q3 and the execute stage.
- o_stall_cycles  out  CNT_W  saturating count of cycles with o_stall_q1=1.
- o_flush_count  out  CNT_W  saturating count of accepted redirects.

## Operation
- States: RUN, FLUSH, MCWAIT. The flush counter is 4 bits. Reset state is RUN with counter 0 and both perf counters 0.
- Control outputs are combinational from the current state and inputs. State and counters are registered.
- Priority within one cycle: redirect > multi-cycle > load-use.
- Load-use condition (LU): i_q3_mem_read && i_q3_rd != 0 && ((i_q2_uses_rs1 && i_q2_rs1 == i_q3_rd) || (i_q2_uses_rs2 && i_q2_rs2 == i_q3_rd)).
- RUN:
  - If i_q3_redirect: o_flush_q1q2=1 and o_bubble_q2q3=1. i_q3_mc_start is ignored. If FLUSH_CYCLES>0, go to FLUSH with count=FLUSH_CYCLES; otherwise stay in RUN. o_flush_count increments.
  - Else if i_q3_mc_start: o_stall_q1=1 and o_hold_q3=1, unless i_mc_done=1 in the same cycle, in which case nothing is asserted and the state stays RUN. Otherwise go to MCWAIT.
  - Else if LU: o_stall_q1=1 and o_bubble_q2q3=1. State stays RUN; the bubble clears the hazard by the next cycle.
- FLUSH:
  - o_flush_q1q2=1. The counter decrements each cycle; return to RUN in the cycle after count reaches 1.
  - LU and i_q3_mc_start are ignored.
  - A new i_q3_redirect asserts o_bubble_q2q3, reloads count=FLUSH_CYCLES and increments o_flush_count.
- MCWAIT:
  - o_stall_q1=1 and o_hold_q3=1 every cycle until i_mc_done=1. In that cycle both are 0 and the state returns to RUN.
  - LU, i_q3_mc_start and i_q3_redirect are ignored; the held q3 instruction cannot be a load or branch.
- Counters saturate at all-ones and never wrap.

## Timing
- Load-use: one stall cycle. Asserted in the same cycle LU is true, zero-latency combinational.
- Redirect at cycle N: o_bubble_q2q3 is high in N only. o_flush_q1q2 is high in N through N+FLUSH_CYCLES. RUN is re-entered at N+FLUSH_CYCLES+1.
- Multi-cycle start at N with done at M>N: o_stall_q1 and o_hold_q3 are high in N..M-1 and low in M. That gives M-N stall cycles.
- o_stall_cycles reflects a stall cycle on the following clock edge.
- Reset asserted mid-FLUSH or mid-MCWAIT: outputs drop to 0 immediately (asynchronous). State returns to RUN and counters clear. After release, operation restarts from RUN on the next edge.

## Test plan
- Load-use: q3 load rd=5, q2 uses rs2=5 → one cycle with o_stall_q1=1 and o_bubble_q2q3=1. o_stall_cycles goes 0→1. Repeat with rd=0, or with i_q2_uses_rs2=0 → no stall.
- Redirect with FLUSH_CYCLES=2 at cycle 10 → o_flush_q1q2 high in cycles 10–12, o_bubble_q2q3 high in cycle 10 only, o_flush_count=1. A simultaneous LU in cycle 11 produces no stall.
- Multi-cycle start at cycle 4, done at cycle 9 → o_hold_q3 and o_stall_q1 high in cycles 4–8, low in 9, o_stall_cycles=5. Start and done in the same cycle → no stall.
- Redirect and mc_start in the same cycle → flush behaviour only; MCWAIT is never entered.
- Reset pulse during MCWAIT → outputs 0 during reset. A later load-use stalls normally, and counters restart from 0.
- Saturation with CNT_W=4: 20 consecutive stall cycles → o_stall_cycles holds at 15.
